// File: rtl/beta_stim_sequencer.sv
// Multi-channel instruction stimulus sequencer: per-channel FIFOs merged by a
// round-robin / fixed-priority arbiter into one registered valid/ready stream.
// Optional opcode histogram is enabled by defining BETA_STIM_OPCODE_HIST_EN.
module beta_stim_sequencer #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int CNT_W = 16,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH*IW-1:0]   in_inst,
  output logic [N_CH-1:0]      in_ready,
  input  logic                 arb_mode,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [IW-1:0]        out_inst,
  output logic [CW-1:0]        out_ch,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic                 empty_all
`ifdef BETA_STIM_OPCODE_HIST_EN
  ,
  input  logic [5:0]           hist_sel,
  output logic [CNT_W-1:0]     hist_cnt
`endif
);

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] pop_vec;
  logic [IW-1:0]   head_data [N_CH];

  logic            out_valid_reg;
  logic [IW-1:0]   out_inst_reg;
  logic [CW-1:0]   out_ch_reg;
  logic [CW-1:0]   rr_ptr_reg;
  logic [CNT_W-1:0] issue_cnt_reg;

  logic            load;
  logic            do_load;
  logic            handshake;
  logic            grant_found;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   cand_idx;
  logic [CW-1:0]   rr_ptr_next;

  // The output register may refill whenever it is empty or being drained;
  // flush suppresses both pop and handshake accounting for that cycle.
  assign load      = !out_valid_reg || out_ready;
  assign do_load   = load && !flush;
  assign handshake = out_valid_reg && out_ready && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [IW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic          push;
      logic          pop;

      assign push = in_valid[gi] && in_ready[gi] && !flush;
      assign pop  = pop_vec[gi];

      always_ff @(posedge CLK) begin
        if (RST && push)
          mem[wr_ptr_reg] <= in_inst[gi*IW +: IW];
      end

      always_ff @(posedge CLK) begin
        if (!RST || flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (push && !pop)
            count_reg <= count_reg + 1'b1;
          else if (!push && pop)
            count_reg <= count_reg - 1'b1;
        end
      end

      assign in_ready[gi]  = (count_reg != (AW+1)'(DEPTH));
      assign elig[gi]      = (count_reg != '0);
      assign head_data[gi] = mem[rd_ptr_reg];
    end
  endgenerate

  // Winner selection: lowest index in fixed mode, first eligible at or after
  // the rotating pointer in round-robin mode.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_mode)
        cand_idx = CW'(i);
      else
        cand_idx = CW'((int'(rr_ptr_reg) + i) % N_CH);
      if (!grant_found && elig[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign rr_ptr_next = (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    pop_vec = '0;
    if (do_load && grant_found)
      pop_vec[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_valid_reg <= 1'b0;
      out_inst_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
      issue_cnt_reg <= '0;
    end else begin
      if (handshake)
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (load) begin
        if (grant_found) begin
          out_valid_reg <= 1'b1;
          out_inst_reg  <= head_data[grant_idx];
          out_ch_reg    <= grant_idx;
          if (!arb_mode)
            rr_ptr_reg <= rr_ptr_next;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_inst  = out_inst_reg;
  assign out_ch    = out_ch_reg;
  assign issue_cnt = issue_cnt_reg;
  assign empty_all = (elig == '0) && !out_valid_reg;

`ifdef BETA_STIM_OPCODE_HIST_EN
  logic [5:0]       opcode;
  logic [CNT_W-1:0] hist_reg [64];

  assign opcode = out_inst_reg[IW-1 -: 6];

  // Saturating per-opcode counters; survive flush, cleared only by reset.
  generate
    for (gi = 0; gi < 64; gi++) begin : g_hist
      always_ff @(posedge CLK) begin
        if (!RST)
          hist_reg[gi] <= '0;
        else if (handshake && opcode == 6'(gi) && hist_reg[gi] != '1)
          hist_reg[gi] <= hist_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign hist_cnt = hist_reg[hist_sel];
`endif

endmodule

// File: tb/tb_beta_stim_sequencer.sv
// Directed testbench for beta_stim_sequencer (N_CH=4, DEPTH=8, IW=32, CNT_W=16).
// Exercises the opcode histogram when BETA_STIM_OPCODE_HIST_EN is defined.
module tb_beta_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [127:0] in_inst;
  logic [3:0]  in_ready;
  logic        arb_mode;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [15:0] issue_cnt;
  logic        empty_all;
`ifdef BETA_STIM_OPCODE_HIST_EN
  logic [5:0]  hist_sel;
  logic [15:0] hist_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  beta_stim_sequencer #(.N_CH(4), .DEPTH(8), .IW(32), .CNT_W(16)) dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .arb_mode  (arb_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .issue_cnt (issue_cnt),
    .empty_all (empty_all)
`ifdef BETA_STIM_OPCODE_HIST_EN
    ,
    .hist_sel  (hist_sel),
    .hist_cnt  (hist_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    flush = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    in_valid  = '0;
    in_inst   = '0;
    arb_mode  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
`ifdef BETA_STIM_OPCODE_HIST_EN
    hist_sel  = '0;
`endif

    // Reset and idle
    do_reset();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'hF);
    check("rst_empty_all", 32'(empty_all), 32'd1);
    check("rst_out_inst",  out_inst,       32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);

    // Single push on ch2: two-cycle latency
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_inst[2*32 +: 32] = 32'hC01F0005;
    step();
    in_valid = '0;
    check("single_not_yet_valid", 32'(out_valid), 32'd0);
    check("single_not_empty",     32'(empty_all), 32'd0);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_ch",    32'(out_ch),    32'd2);
    check("single_inst",  out_inst,       32'hC01F0005);
    check("single_cnt_before", 32'(issue_cnt), 32'd0);
    step();
    $display("txn single ch=2 inst=%h", 32'hC01F0005);
    check("single_cnt", 32'(issue_cnt), 32'd1);
    check("single_drained", 32'(out_valid), 32'd0);

    // Round-robin: 2 per channel
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 4; k++)
        in_inst[k*32 +: 32] = 32'hA0000000 | (k << 8) | j;
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_ch",    32'(out_ch),    32'(i % 4));
      check("rr_inst",  out_inst,       32'hA0000000 | ((i % 4) << 8) | (i / 4));
      $display("txn rr ch=%0d inst=%h", out_ch, out_inst);
      step();
    end
    check("rr_issue_cnt", 32'(issue_cnt), 32'd8);
    check("rr_drained",   32'(out_valid), 32'd0);

    // Fixed priority: ch0 and ch3 with 3 each
    arb_mode  = 1'b1;
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    for (int j = 0; j < 3; j++) begin
      in_inst[0*32 +: 32] = 32'h50000000 | j;
      in_inst[3*32 +: 32] = 32'h50000300 | j;
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("fp_ch",   32'(out_ch), (i < 3) ? 32'd0 : 32'd3);
      check("fp_inst", out_inst, (i < 3) ? (32'h50000000 | i) : (32'h50000300 | (i - 3)));
      $display("txn fp ch=%0d inst=%h", out_ch, out_inst);
      step();
    end
    check("fp_issue_cnt", 32'(issue_cnt), 32'd14);
    arb_mode = 1'b0;

    // Fill ch1 while the output stage stalls on a ch0 instruction
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_inst[0*32 +: 32] = 32'h12345678;
    step();
    in_valid = '0;
    step();
    check("stall_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0010;
    for (int j = 0; j < 8; j++) begin
      in_inst[1*32 +: 32] = 32'hB0000000 | j;
      step();
    end
    check("full_in_ready", 32'(in_ready), 32'b1101);
    in_inst[1*32 +: 32] = 32'hDEADBEEF;
    step();
    in_valid = '0;
    check("stall_inst_held", out_inst,       32'h12345678);
    check("stall_ch_held",   32'(out_ch),    32'd0);
    check("stall_cnt",       32'(issue_cnt), 32'd14);
    out_ready = 1'b1;
    step();
    for (int j = 0; j < 8; j++) begin
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_ch",    32'(out_ch),    32'd1);
      check("full_inst",  out_inst,       32'hB0000000 | j);
      $display("txn fill ch=%0d inst=%h", out_ch, out_inst);
      step();
    end
    check("full_no_ninth", 32'(out_valid), 32'd0);
    check("full_issue_cnt", 32'(issue_cnt), 32'd23);
    check("full_in_ready_back", 32'(in_ready), 32'hF);

    // Flush with 5 queued and a held output
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int j = 0; j < 6; j++) begin
      in_inst[2*32 +: 32] = 32'h70000000 | j;
      step();
    end
    in_valid = '0;
    check("preflush_valid", 32'(out_valid), 32'd1);
    check("preflush_empty", 32'(empty_all), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_empty",    32'(empty_all), 32'd1);
    check("flush_cnt",      32'(issue_cnt), 32'd23);
    check("flush_in_ready", 32'(in_ready),  32'hF);

    // Sequencer still functional after flush
    out_ready = 1'b1;
    in_valid  = 4'b1000;
    in_inst[3*32 +: 32] = 32'h30000001;
    step();
    in_valid = '0;
    step();
    check("postflush_ch",   32'(out_ch), 32'd3);
    check("postflush_inst", out_inst,    32'h30000001);
    step();
    $display("txn postflush ch=3 inst=%h", 32'h30000001);
    check("postflush_cnt", 32'(issue_cnt), 32'd24);

`ifdef BETA_STIM_OPCODE_HIST_EN
    in_valid = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      in_inst[0*32 +: 32] = 32'h60000000 | j;
      step();
    end
    in_valid = '0;
    step();
    step();
    step();
    hist_sel = 6'h18;
    #1;
    check("hist_18", 32'(hist_cnt), 32'd3);
    hist_sel = 6'h28;
    #1;
    check("hist_28", 32'(hist_cnt), 32'd8);
    check("hist_issue_cnt", 32'(issue_cnt), 32'd27);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
